// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - programmable note-table player driving one signal generator
// Optional build macro NOTE_SEQUENCER_LOOP_EN: wrap to entry 0 instead of ending.
module note_sequencer #(
  parameter int DEPTH        = 16,
  parameter int TICKS_PER_MS = 32,
  parameter int GAP_TICKS    = 64
) (
  input  logic                     CLK_32KHz,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [23:0]              wr_data,
  output logic [13:0]              outputFrequency,
  output logic                     noteActive,
  output logic                     gen_reset_n,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] noteIndex
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [19:0]     TPM      = 20'(TICKS_PER_MS);
  localparam logic [19:0]     GAP_LAST = 20'(GAP_TICKS - 1);
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE} state_t;

  state_t          r_state, w_state_next;
  logic [AW-1:0]   r_index, w_index_next;
  logic [19:0]     r_count, w_count_next;
  logic [13:0]     r_freq, w_freq_next;
  logic            r_first, w_first_next;
  logic [23:0]     r_table [DEPTH];
  logic [23:0]     w_entry;
  logic [9:0]      w_dur;
  logic [13:0]     w_freq_raw;
  logic [13:0]     w_freq_clamped;
  logic            w_step;
  logic            w_end;
`ifdef NOTE_SEQUENCER_LOOP_EN
  logic            r_wrap, w_wrap_next;
`endif

  assign w_entry    = r_table[r_index];
  assign w_dur      = w_entry[9:0];
  assign w_freq_raw = w_entry[23:10];

  always_comb begin
    w_freq_clamped = w_freq_raw;
    if (w_freq_raw == 14'd0)
      w_freq_clamped = 14'd0;
    else if (w_freq_raw < 14'd100)
      w_freq_clamped = 14'd100;
    else if (w_freq_raw > 14'd8000)
      w_freq_clamped = 14'd8000;
  end

  // Table is written only while idle and deliberately has no reset.
  always_ff @(posedge CLK_32KHz) begin
    if (wr_en && r_state == S_IDLE)
      r_table[wr_addr] <= wr_data;
  end

  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    w_count_next = r_count;
    w_freq_next  = r_freq;
    w_first_next = 1'b0;
    w_step       = 1'b0;
    w_end        = 1'b0;
`ifdef NOTE_SEQUENCER_LOOP_EN
    w_wrap_next  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state_next = S_LOAD;
          w_index_next = '0;
        end
      end
      S_LOAD: begin
        if (w_dur == 10'd0) begin
          w_end = 1'b1;
        end else begin
          w_state_next = S_PLAY;
          w_count_next = 20'(w_dur) * TPM - 20'd1;
          w_freq_next  = w_freq_clamped;
          w_first_next = 1'b1;
        end
      end
      S_PLAY: begin
        if (r_count == 20'd0) begin
          if (GAP_TICKS > 0) begin
            w_state_next = S_GAP;
            w_count_next = GAP_LAST;
          end else begin
            w_step = 1'b1;
          end
        end else begin
          w_count_next = r_count - 20'd1;
        end
      end
      S_GAP: begin
        if (r_count == 20'd0)
          w_step = 1'b1;
        else
          w_count_next = r_count - 20'd1;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_index_next = '0;
      end
      default: begin
        w_state_next = S_IDLE;
        w_index_next = '0;
      end
    endcase

    if (w_step) begin
      if (r_index == LAST_IDX) begin
        w_end = 1'b1;
      end else begin
        w_state_next = S_LOAD;
        w_index_next = r_index + AW'(1);
      end
    end

    if (w_end) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
      w_state_next = S_LOAD;
      w_index_next = '0;
      w_wrap_next  = 1'b1;
`else
      w_state_next = S_DONE;
`endif
    end

    // stop overrides every other transition, including a same-cycle start.
    if (stop && r_state != S_IDLE) begin
      w_state_next = S_IDLE;
      w_index_next = '0;
    end
  end

  always_ff @(posedge CLK_32KHz) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_count <= '0;
      r_freq  <= '0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
      r_count <= w_count_next;
      r_freq  <= w_freq_next;
      r_first <= w_first_next;
    end
  end

`ifdef NOTE_SEQUENCER_LOOP_EN
  always_ff @(posedge CLK_32KHz) begin
    if (reset)
      r_wrap <= 1'b0;
    else
      r_wrap <= w_wrap_next;
  end
`endif

  always_comb begin
    outputFrequency = (r_state == S_PLAY) ? r_freq : 14'd0;
    noteActive      = (r_state == S_PLAY) && (r_freq != 14'd0);
    gen_reset_n     = !((r_state == S_PLAY) && r_first);
    busy            = (r_state != S_IDLE);
    noteIndex       = r_index;
`ifdef NOTE_SEQUENCER_LOOP_EN
    done            = (r_state == S_LOAD) && r_wrap;
`else
    done            = (r_state == S_DONE);
`endif
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - randomized self-checking bench for note_sequencer
// Instance a uses GAP_TICKS=64, instance b uses GAP_TICKS=0.
module tb_note_sequencer;

  localparam int DEPTH = 16;
  localparam int TPM   = 32;
  localparam int GAP_A = 64;
  localparam int GAP_B = 0;

  typedef struct packed {
    logic [13:0] freq;
    logic        active;
    logic        grn;
    logic        busy;
    logic        done;
    logic [3:0]  idx;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [23:0] wr_data;
  logic        start_a, stop_a, start_b, stop_b;
  logic [13:0] freq_a, freq_b;
  logic        active_a, active_b, grn_a, grn_b, busy_a, busy_b, done_a, done_b;
  logic [3:0]  idx_a, idx_b;

  obs_t        exp_q[$];
  logic [23:0] m_tab [DEPTH];
  obs_t        idle_obs;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  note_sequencer #(.DEPTH(DEPTH), .TICKS_PER_MS(TPM), .GAP_TICKS(GAP_A)) u_dut_a (
    .CLK_32KHz(clk), .reset(reset), .start(start_a), .stop(stop_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .outputFrequency(freq_a), .noteActive(active_a), .gen_reset_n(grn_a),
    .busy(busy_a), .done(done_a), .noteIndex(idx_a)
  );

  note_sequencer #(.DEPTH(DEPTH), .TICKS_PER_MS(TPM), .GAP_TICKS(GAP_B)) u_dut_b (
    .CLK_32KHz(clk), .reset(reset), .start(start_b), .stop(stop_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .outputFrequency(freq_b), .noteActive(active_b), .gen_reset_n(grn_b),
    .busy(busy_b), .done(done_b), .noteIndex(idx_b)
  );

  function automatic obs_t get_obs(input int which);
    obs_t o;
    if (which == 0) begin
      o.freq = freq_a; o.active = active_a; o.grn = grn_a;
      o.busy = busy_a; o.done = done_a; o.idx = idx_a;
    end else begin
      o.freq = freq_b; o.active = active_b; o.grn = grn_b;
      o.busy = busy_b; o.done = done_b; o.idx = idx_b;
    end
    return o;
  endfunction

  function automatic logic [13:0] clamp_hz(input logic [13:0] f);
    if (f == 0)     return 14'd0;
    if (f < 100)    return 14'd100;
    if (f > 8000)   return 14'd8000;
    return f;
  endfunction

  function automatic obs_t mk(input logic [13:0] f, input logic a, input logic g,
                              input logic b, input logic d, input int i);
    obs_t o;
    o.freq = f; o.active = a; o.grn = g; o.busy = b; o.done = d; o.idx = 4'(i);
    return o;
  endfunction

  // Cycle-by-cycle expectation from the cycle after start is sampled to the last busy cycle.
  task automatic build_trace(input int gap);
    int dur;
    logic [13:0] f;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(mk(14'd0, 1'b0, 1'b1, 1'b1, 1'b0, i));
      dur = int'(m_tab[i][9:0]);
      f   = clamp_hz(m_tab[i][23:10]);
      if (dur == 0) begin
        exp_q.push_back(mk(14'd0, 1'b0, 1'b1, 1'b1, 1'b1, i));
        return;
      end
      for (int k = 0; k < dur * TPM; k++)
        exp_q.push_back(mk(f, f != 0, k != 0, 1'b1, 1'b0, i));
      for (int k = 0; k < gap; k++)
        exp_q.push_back(mk(14'd0, 1'b0, 1'b1, 1'b1, 1'b0, i));
      if (i == DEPTH - 1)
        exp_q.push_back(mk(14'd0, 1'b0, 1'b1, 1'b1, 1'b1, i));
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start_a = v; else start_b = v;
  endtask

  task automatic write_entry(input int addr, input logic [13:0] f, input logic [9:0] d);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_data = {f, d};
    m_tab[addr] = {f, d};
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_check(input int which, input string name, input int intrude_at,
                           output int grn_lows);
    obs_t o;
    grn_lows = 0;
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    for (int c = 0; c < exp_q.size(); c++) begin
      o = get_obs(which);
      checks++;
      if (o !== exp_q[c]) begin
        errors++;
        $display("FAIL %s cycle %0d got %h expected %h", name, c, o, exp_q[c]);
      end
      if (o.grn == 1'b0) grn_lows++;
      if (c == intrude_at) begin
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = {14'd1234, 10'd3};
        set_start(which, 1'b1);
      end else if (c == intrude_at + 1) begin
        wr_en = 1'b0;
        set_start(which, 1'b0);
      end
      @(negedge clk);
    end
    o = get_obs(which);
    checks++;
    if (o !== idle_obs) begin
      errors++;
      $display("FAIL %s_idle_after got %h expected %h", name, o, idle_obs);
    end
  endtask

  task automatic write_basic_table();
    write_entry(0, 14'd440, 10'd2);
    write_entry(1, 14'd0, 10'd1);
    write_entry(2, 14'd9000, 10'd1);
    write_entry(3, 14'd0, 10'd0);
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      o = get_obs(w);
      checks++;
      if (o !== idle_obs) begin
        errors++;
        $display("FAIL reset_values dut%0d got %h expected %h", w, o, idle_obs);
      end
    end
  endtask

  task automatic test_basic_sequence();
    int lows;
    write_basic_table();
    build_trace(GAP_A);
    run_check(0, "basic_seq", -1, lows);
    checks++;
    if (lows !== 3) begin
      errors++;
      $display("FAIL basic_seq_restart_pulses got %0d expected 3", lows);
    end
  endtask

  task automatic test_table_end();
    int lows;
    for (int i = 0; i < DEPTH; i++) write_entry(i, 14'd50, 10'd1);
    build_trace(GAP_B);
    run_check(1, "table_end", -1, lows);
    checks++;
    if (lows !== 16) begin
      errors++;
      $display("FAIL table_end_restart_pulses got %0d expected 16", lows);
    end
  endtask

  task automatic test_stop();
    obs_t o;
    logic saw;
    write_basic_table();
    build_trace(GAP_A);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    o = get_obs(0);
    checks++;
    if (o !== exp_q[10]) begin
      errors++;
      $display("FAIL stop_pre got %h expected %h", o, exp_q[10]);
    end
    stop_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0; start_a = 1'b0;
    o = get_obs(0);
    checks++;
    if (o !== idle_obs) begin
      errors++;
      $display("FAIL stop_idle got %h expected %h", o, idle_obs);
    end
    saw = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy_a || done_a) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL stop_no_done got %b expected 0", saw);
    end
  endtask

  task automatic test_busy_protect();
    int lows;
    write_entry(0, 14'd440, 10'd1);
    write_entry(1, 14'd0, 10'd0);
    build_trace(GAP_A);
    run_check(0, "protect_run", 5, lows);
    run_check(0, "protect_replay", -1, lows);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int lows;
    write_basic_table();
    build_trace(GAP_A);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    o = get_obs(0);
    checks++;
    if (o !== idle_obs) begin
      errors++;
      $display("FAIL reset_mid got %h expected %h", o, idle_obs);
    end
    run_check(0, "reset_mid_replay", -1, lows);
  endtask

  task automatic test_random();
    int lows;
    int which;
    logic [13:0] f;
    logic [9:0]  d;
    for (int it = 0; it < 6; it++) begin
      which = it % 2;
      for (int i = 0; i < DEPTH; i++) begin
        case ($urandom_range(0, 3))
          0:       f = 14'd0;
          1:       f = 14'($urandom_range(1, 99));
          2:       f = 14'($urandom_range(100, 8000));
          default: f = 14'($urandom_range(8001, 16383));
        endcase
        d = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 2));
        write_entry(i, f, d);
      end
      build_trace(which == 0 ? GAP_A : GAP_B);
      run_check(which, "random", -1, lows);
    end
  endtask

  initial begin
    idle_obs = mk(14'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
    @(negedge clk);
    test_reset();
    test_basic_sequence();
    test_table_end();
    test_stop();
    test_busy_protect();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
